// File: rtl/dlx_mem_pkg.sv
// Shared address map constants, STATUS bit positions and read-source encoding
// for the DLX data-memory bridge.
package dlx_mem_pkg;

   localparam logic [3:0]  RAM_REGION     = 4'h0;
   localparam logic [31:0] GPIO_ADDR      = 32'hF000_0000;
   localparam logic [31:0] TX_ADDR        = 32'hF000_0004;
   localparam logic [31:0] CYCLE_CNT_ADDR = 32'hF000_0008;

   localparam int unsigned STATUS_EMPTY_BIT = 0;
   localparam int unsigned STATUS_FULL_BIT  = 1;
   localparam int unsigned STATUS_OVF_BIT   = 2;

   typedef enum logic [1:0] {
      SEL_NONE = 2'd0,
      SEL_RAM  = 2'd1,
      SEL_MMIO = 2'd2
   } rd_sel_e;

endpackage

// File: rtl/dlx_sp_ram.sv
// Single-port RAM with synchronous read and write enable; contents are not reset.
module dlx_sp_ram #(
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned ADDR_WIDTH = 10
) (
   input  logic                  clk,
   input  logic                  we,
   input  logic [ADDR_WIDTH-1:0] addr,
   input  logic [DATA_WIDTH-1:0] wdata,
   output logic [DATA_WIDTH-1:0] rdata
);

   localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;

   logic [DATA_WIDTH-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (we) begin
         mem[addr] <= wdata;
      end
      rdata <= mem[addr];
   end

endmodule

// File: rtl/dlx_data_mem_bridge.sv
// DLX data-port bridge: word RAM, GPIO register, TX stream FIFO and optional
// cycle counter (enabled by defining DLX_CYCLE_COUNTER_EN).
module dlx_data_mem_bridge
   import dlx_mem_pkg::*;
#(
   parameter int unsigned DATA_WIDTH      = 32,
   parameter int unsigned DATA_ADDR_WIDTH = 32,
   parameter int unsigned RAM_ADDR_WIDTH  = 10,
   parameter int unsigned TX_FIFO_DEPTH   = 4
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       data_rd_en,
   input  logic                       data_wr_en,
   input  logic [DATA_ADDR_WIDTH-1:0] data_addr,
   input  logic [DATA_WIDTH-1:0]      data_write,
   output logic [DATA_WIDTH-1:0]      data_read,
   output logic [DATA_WIDTH-1:0]      gpio_out,
   output logic                       tx_valid,
   output logic [DATA_WIDTH-1:0]      tx_data,
   input  logic                       tx_ready,
   output logic                       addr_err
);

   localparam int unsigned PTR_W = $clog2(TX_FIFO_DEPTH);
   localparam int unsigned CNT_W = PTR_W + 1;
`ifdef DLX_CYCLE_COUNTER_EN
   localparam bit HAS_CNT = 1'b1;
`else
   localparam bit HAS_CNT = 1'b0;
`endif

   logic                  is_ram, is_gpio, is_tx, is_cnt, mapped;
   logic                  wr, rd;
   logic                  unused_addr_lsb;
   logic [DATA_WIDTH-1:0] ram_rdata;
   logic [DATA_WIDTH-1:0] mmio_rdata, mmio_q, status_word;
   rd_sel_e               rd_sel;

   logic [DATA_WIDTH-1:0] fifo_mem [TX_FIFO_DEPTH];
   logic [PTR_W-1:0]      rd_ptr, wr_ptr;
   logic [CNT_W-1:0]      count, count_nxt;
   logic                  overflow, push, pop, accept, status_rd, full, empty;

   // Word-granular decode; the byte offset is intentionally ignored.
   assign unused_addr_lsb = ^data_addr[1:0];
   assign is_ram  = (data_addr[31:28] == RAM_REGION);
   assign is_gpio = (data_addr[31:2] == GPIO_ADDR[31:2]);
   assign is_tx   = (data_addr[31:2] == TX_ADDR[31:2]);
   assign is_cnt  = HAS_CNT && (data_addr[31:2] == CYCLE_CNT_ADDR[31:2]);
   assign mapped  = is_ram | is_gpio | is_tx | is_cnt;

   // A store takes priority over a simultaneous load; reset aborts both.
   assign wr = data_wr_en & ~rst;
   assign rd = data_rd_en & ~data_wr_en & ~rst;

   dlx_sp_ram #(
      .DATA_WIDTH(DATA_WIDTH),
      .ADDR_WIDTH(RAM_ADDR_WIDTH)
   ) u_ram (
      .clk  (clk),
      .we   (wr & is_ram),
      .addr (data_addr[RAM_ADDR_WIDTH+1:2]),
      .wdata(data_write),
      .rdata(ram_rdata)
   );

`ifdef DLX_CYCLE_COUNTER_EN
   logic [31:0] cycle_cnt;

   always_ff @(posedge clk) begin
      if (rst) begin
         cycle_cnt <= '0;
      end else begin
         cycle_cnt <= cycle_cnt + 32'd1;
      end
   end
`endif

   assign empty     = (count == '0);
   assign full      = (count == CNT_W'(TX_FIFO_DEPTH));
   assign pop       = ~empty & tx_ready;
   assign push      = wr & is_tx;
   assign accept    = push & (~full | pop);
   assign status_rd = rd & is_tx;
   assign tx_data   = fifo_mem[rd_ptr];

   always_comb begin
      status_word                   = '0;
      status_word[STATUS_EMPTY_BIT] = empty;
      status_word[STATUS_FULL_BIT]  = full;
      status_word[STATUS_OVF_BIT]   = overflow;
   end

   always_comb begin
      mmio_rdata = '0;
      if (is_gpio) begin
         mmio_rdata = gpio_out;
      end else if (is_tx) begin
         mmio_rdata = status_word;
      end
`ifdef DLX_CYCLE_COUNTER_EN
      else if (is_cnt) begin
         mmio_rdata = DATA_WIDTH'(cycle_cnt);
      end
`endif
   end

   always_comb begin
      count_nxt = count;
      case ({accept, pop})
         2'b10:   count_nxt = count + CNT_W'(1);
         2'b01:   count_nxt = count - CNT_W'(1);
         default: count_nxt = count;
      endcase
   end

   // Read source is registered with the access so data_read lines up with RAM latency.
   always_ff @(posedge clk) begin
      if (rst) begin
         rd_sel   <= SEL_NONE;
         mmio_q   <= '0;
         gpio_out <= '0;
         addr_err <= 1'b0;
      end else begin
         addr_err <= (data_rd_en | data_wr_en) & ~mapped;
         mmio_q   <= rd ? mmio_rdata : '0;
         if (rd && is_ram) begin
            rd_sel <= SEL_RAM;
         end else if (rd && mapped) begin
            rd_sel <= SEL_MMIO;
         end else begin
            rd_sel <= SEL_NONE;
         end
         if (wr && is_gpio) begin
            gpio_out <= data_write;
         end
      end
   end

   always_comb begin
      case (rd_sel)
         SEL_RAM:  data_read = ram_rdata;
         SEL_MMIO: data_read = mmio_q;
         default:  data_read = '0;
      endcase
   end

   // TX FIFO: a push into a full FIFO still fits when the head leaves the same cycle.
   always_ff @(posedge clk) begin
      if (rst) begin
         rd_ptr   <= '0;
         wr_ptr   <= '0;
         count    <= '0;
         overflow <= 1'b0;
         tx_valid <= 1'b0;
         for (int unsigned i = 0; i < TX_FIFO_DEPTH; i++) begin
            fifo_mem[i] <= '0;
         end
      end else begin
         count    <= count_nxt;
         tx_valid <= (count_nxt != '0);
         if (pop) begin
            rd_ptr <= rd_ptr + PTR_W'(1);
         end
         if (accept) begin
            fifo_mem[wr_ptr] <= data_write;
            wr_ptr           <= wr_ptr + PTR_W'(1);
         end
         if (push && !accept) begin
            overflow <= 1'b1;
         end else if (status_rd) begin
            overflow <= 1'b0;
         end
      end
   end

endmodule
